// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: size encodings,
// FSM states, the captured request record and small decode helpers.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } lsu_req_t;

  // Byte-lane mask of an access before it is moved to its lane offset.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Lane steering for the 64-bit bus: store data/strobe placement and
// load extraction with sign or zero extension. Purely combinational.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic        wen,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata_raw,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ext
);

  logic [63:0] rd_sh;

  always_comb begin
    wstrb    = wen ? (size_mask(size) << addr_lo) : 8'h00;
    wdata_sh = wdata << {addr_lo, 3'b000};
    rd_sh    = rdata_raw >> {addr_lo, 3'b000};
    case (size)
      SZ_B:    rdata_ext = {{56{~uns & rd_sh[7]}},  rd_sh[7:0]};
      SZ_H:    rdata_ext = {{48{~uns & rd_sh[15]}}, rd_sh[15:0]};
      SZ_W:    rdata_ext = {{32{~uns & rd_sh[31]}}, rd_sh[31:0]};
      default: rdata_ext = rd_sh;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: stalls the pipeline while one access runs
// over a valid/ready request + response bus, with misalign and timeout errors.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        stall,
  output logic        done,
  output logic [63:0] rdata,
  output logic        err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_wen,
  output logic [63:0] bus_req_addr,
  output logic [63:0] bus_req_wdata,
  output logic [7:0]  bus_req_wstrb,
  input  logic        bus_resp_valid,
  input  logic [63:0] bus_resp_rdata,
  output logic        bus_resp_ready
);

  // One spare count above the limit so RESP can compare with >=.
  localparam int CW = $clog2(TIMEOUT_CYC + 2);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYC);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0]  al_wstrb;
  logic [63:0] al_wdata;
  logic [63:0] al_rdata;
  logic        live;

  lsu_align u_align (
    .size      (req_q.size),
    .uns       (req_q.uns),
    .wen       (req_q.wen),
    .addr_lo   (req_q.addr[2:0]),
    .wdata     (req_q.wdata),
    .rdata_raw (bus_resp_rdata),
    .wstrb     (al_wstrb),
    .wdata_sh  (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (misaligned(req_addr[2:0], req_size)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = ST_REQ;
            req_d.wen   = req_wen;
            req_d.addr  = req_addr;
            req_d.wdata = req_wdata;
            req_d.size  = req_size;
            req_d.uns   = req_unsigned;
            cnt_d       = '0;
            err_d       = 1'b0;
          end
        end
      end

      ST_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_req_ready) begin
          state_d = ST_RESP;
        end else if (cnt_q == TO_VAL) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end

      // The counter keeps running from REQ, so the limit bounds the whole access.
      ST_RESP: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_resp_valid) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          rdata_d = req_q.wen ? 64'd0 : al_rdata;
        end else if (cnt_q >= TO_VAL) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
        rdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the captured request is cleared too, not just the state, so a stale payload never reaches the bus.
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignment lets every flop sample pre-edge values regardless of statement order.
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced low while rst is high, even before the synchronous reset lands.
  assign live           = ~rst;
  assign stall          = live & req_valid & (state_q != ST_DONE);
  assign done           = live & (state_q == ST_DONE);
  assign err            = done & err_q;
  assign rdata          = done ? rdata_q : 64'd0;
  assign bus_req_valid  = live & (state_q == ST_REQ);
  assign bus_req_wen    = bus_req_valid & req_q.wen;
  assign bus_req_addr   = bus_req_valid ? {req_q.addr[63:3], 3'b000} : 64'd0;
  assign bus_req_wdata  = bus_req_valid ? al_wdata : 64'd0;
  assign bus_req_wstrb  = bus_req_valid ? al_wstrb : 8'h00;
  assign bus_resp_ready = live & (state_q == ST_RESP);

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a transaction-level reference model checked
// every cycle, plus hand-computed expectations for each directed access.
module tb_mem_lsu;

  localparam int TO = 255;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        stall;
  logic        done;
  logic [63:0] rdata;
  logic        err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_wen;
  logic [63:0] bus_req_addr;
  logic [63:0] bus_req_wdata;
  logic [7:0]  bus_req_wstrb;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_rdata;
  logic        bus_resp_ready;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  mem_lsu #(.TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_wen        (req_wen),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .stall          (stall),
    .done           (done),
    .rdata          (rdata),
    .err            (err),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_req_wen    (bus_req_wen),
    .bus_req_addr   (bus_req_addr),
    .bus_req_wdata  (bus_req_wdata),
    .bus_req_wstrb  (bus_req_wstrb),
    .bus_resp_valid (bus_resp_valid),
    .bus_resp_rdata (bus_resp_rdata),
    .bus_resp_ready (bus_resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic logic f_misal(input logic [63:0] a, input logic [1:0] s);
    return (int'(a[2:0]) % nbytes(s)) != 0;
  endfunction

  function automatic logic [7:0] f_strb(input logic [63:0] a, input logic [1:0] s);
    logic [7:0] v;
    int off;
    v   = '0;
    off = int'(a[2:0]);
    for (int i = 0; i < nbytes(s); i++) v[off + i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] f_load(input logic [63:0] resp, input logic [63:0] a,
                                         input logic [1:0] s, input logic uns);
    logic [63:0] v;
    int off;
    int n;
    v   = '0;
    off = int'(a[2:0]);
    n   = nbytes(s);
    for (int i = 0; i < n; i++) v[8*i +: 8] = resp[8*(off + i) +: 8];
    if (!uns && n < 8 && v[8*n - 1])
      for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
    return v;
  endfunction

  // Transaction view: busy = access outstanding, acc = request accepted by bus,
  // age = cycles since the access was captured.
  logic        m_busy = 0, m_acc = 0, m_done = 0, m_err = 0, m_wen = 0, m_uns = 0;
  logic [63:0] m_rdata = 0, m_addr = 0, m_baddr = 0, m_bwdata = 0;
  logic [7:0]  m_bstrb = 0;
  logic [1:0]  m_size = 0;
  int          m_age = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_acc <= 0; m_done <= 0; m_err <= 0; m_rdata <= 0; m_age <= 0;
    end else if (m_done) begin
      m_done <= 0; m_err <= 0; m_rdata <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        if (f_misal(req_addr, req_size)) begin
          m_done <= 1; m_err <= 1; m_rdata <= 0;
        end else begin
          m_busy   <= 1; m_acc <= 0; m_age <= 0;
          m_wen    <= req_wen;
          m_addr   <= req_addr;
          m_size   <= req_size;
          m_uns    <= req_unsigned;
          m_baddr  <= req_addr & ~64'h7;
          m_bstrb  <= req_wen ? f_strb(req_addr, req_size) : 8'h00;
          m_bwdata <= req_wdata << (8 * int'(req_addr[2:0]));
        end
      end
    end else begin
      m_age <= m_age + 1;
      if (!m_acc) begin
        if (bus_req_ready) m_acc <= 1;
        else if (m_age >= TO) begin
          m_busy <= 0; m_done <= 1; m_err <= 1; m_rdata <= 0;
        end
      end else if (bus_resp_valid) begin
        m_busy <= 0; m_acc <= 0; m_done <= 1; m_err <= 0;
        m_rdata <= m_wen ? 64'd0 : f_load(bus_resp_rdata, m_addr, m_size, m_uns);
      end else if (m_age >= TO) begin
        m_busy <= 0; m_acc <= 0; m_done <= 1; m_err <= 1; m_rdata <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_bus_req_valid", bus_req_valid, 0);
        check("rst_bus_resp_ready", bus_resp_ready, 0);
        check("rst_bus_addr", bus_req_addr, 0);
        check("rst_bus_wstrb", bus_req_wstrb, 0);
        check("rst_bus_wdata", bus_req_wdata, 0);
        check("rst_bus_wen", bus_req_wen, 0);
      end else begin
        check("stall", stall, req_valid && !m_done);
        check("done", done, m_done);
        check("err", err, m_done && m_err);
        check("rdata", rdata, m_done ? m_rdata : 64'd0);
        check("bus_req_valid", bus_req_valid, m_busy && !m_acc);
        check("bus_resp_ready", bus_resp_ready, m_busy && m_acc);
        if (m_busy && !m_acc) begin
          check("bus_req_addr", bus_req_addr, m_baddr);
          check("bus_req_wen", bus_req_wen, m_wen);
          check("bus_req_wstrb", bus_req_wstrb, m_bstrb);
          if (m_wen) check("bus_req_wdata", bus_req_wdata, m_bwdata);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          stalls;
    logic        saw_req;
    logic        bwen;
    logic [63:0] baddr;
    logic [7:0]  bstrb;
    logic [63:0] bwdata;
  } res_t;

  // Presents one access, holds req_valid until done, and scrambles req_* right
  // after capture. ready rises at cycle ready_wait; the response follows bus_resp_ready.
  task automatic do_access(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [1:0] size, input logic uns, input logic [63:0] resp,
                           input int ready_wait, output res_t r);
    bit fin;
    fin       = 0;
    r.rdata   = '0; r.err = 0; r.lat = -1; r.stalls = 0; r.saw_req = 0;
    r.bwen    = 0; r.baddr = '0; r.bstrb = '0; r.bwdata = '0;
    @(posedge clk); #1;
    req_valid      = 1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size       = size; req_unsigned = uns;
    bus_resp_rdata = resp;
    bus_req_ready  = (ready_wait == 0);
    bus_resp_valid = 0;
    for (int c = 0; c < 600 && !fin; c++) begin
      @(negedge clk);
      if (stall) r.stalls++;
      if (bus_req_valid && !r.saw_req) begin
        r.saw_req = 1; r.bwen = bus_req_wen; r.baddr = bus_req_addr;
        r.bstrb = bus_req_wstrb; r.bwdata = bus_req_wdata;
      end
      if (done) begin
        r.rdata = rdata; r.err = err; r.lat = c; fin = 1;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        req_wen = ~wen; req_addr = ~addr; req_wdata = ~wdata; req_size = ~size; req_unsigned = ~uns;
      end
      if (fin) begin
        req_valid = 0; bus_req_ready = 0; bus_resp_valid = 0;
      end else begin
        bus_req_ready  = (c + 1 >= ready_wait);
        bus_resp_valid = bus_resp_ready;
      end
    end
    check("access_completed", fin, 1);
  endtask

  res_t r;
  bit   in_resp;

  initial begin
    rst = 1; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0;
    req_unsigned = 0; bus_req_ready = 0; bus_resp_valid = 0; bus_resp_rdata = 0;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_stall", stall, 0);
    check("reset_done", done, 0);
    check("reset_bus_req_valid", bus_req_valid, 0);
    @(posedge clk); #1;
    rst = 0;

    // LD aligned double
    do_access(0, 64'h8000_0008, 64'h0, 2'b11, 0, 64'h1122_3344_5566_7788, 0, r);
    check("ld_rdata", r.rdata, 64'h1122_3344_5566_7788);
    check("ld_err", r.err, 0);
    check("ld_latency", r.lat, 3);
    check("ld_stall_cycles", r.stalls, 3);
    check("ld_bus_addr", r.baddr, 64'h8000_0008);
    check("ld_bus_wstrb", r.bstrb, 8'h00);
    check("ld_bus_wen", r.bwen, 0);

    // LB signed / LBU
    do_access(0, 64'h8000_0003, 64'h0, 2'b00, 0, 64'h0000_0000_F000_0000, 0, r);
    check("lb_rdata", r.rdata, 64'hFFFF_FFFF_FFFF_FFF0);
    check("lb_bus_addr", r.baddr, 64'h8000_0000);
    do_access(0, 64'h8000_0003, 64'h0, 2'b00, 1, 64'h0000_0000_F000_0000, 0, r);
    check("lbu_rdata", r.rdata, 64'h0000_0000_0000_00F0);

    // SH at lane 6
    do_access(1, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 2'b01, 0, 64'hDEAD_BEEF_CAFE_F00D, 0, r);
    check("sh_bus_wstrb", r.bstrb, 8'hC0);
    check("sh_bus_wdata", r.bwdata, 64'hABCD_0000_0000_0000);
    check("sh_bus_addr", r.baddr, 64'h8000_0000);
    check("sh_bus_wen", r.bwen, 1);
    check("sh_rdata", r.rdata, 64'h0);

    // LW misaligned
    do_access(0, 64'h8000_0002, 64'h0, 2'b10, 0, 64'h0, 0, r);
    check("lw_mis_err", r.err, 1);
    check("lw_mis_latency", r.lat, 1);
    check("lw_mis_bus_req", r.saw_req, 0);
    check("lw_mis_stall_cycles", r.stalls, 1);
    check("lw_mis_rdata", r.rdata, 64'h0);

    // LH signed with a slow bus
    do_access(0, 64'h8000_000A, 64'h0, 2'b01, 0, 64'h0000_0000_8001_0000, 3, r);
    check("lh_rdata", r.rdata, 64'hFFFF_FFFF_FFFF_8001);
    check("lh_latency", r.lat, 5);
    check("lh_bus_addr", r.baddr, 64'h8000_0008);

    // SW upper lane, LWU upper lane
    do_access(1, 64'h8000_0004, 64'h0000_0000_1234_5678, 2'b10, 0, 64'h0, 0, r);
    check("sw_bus_wstrb", r.bstrb, 8'hF0);
    check("sw_bus_wdata", r.bwdata, 64'h1234_5678_0000_0000);
    do_access(0, 64'h8000_0004, 64'h0, 2'b10, 1, 64'hFEDC_BA98_0000_0000, 0, r);
    check("lwu_rdata", r.rdata, 64'h0000_0000_FEDC_BA98);

    // SD misaligned
    do_access(1, 64'h8000_0004, 64'h55, 2'b11, 0, 64'h0, 0, r);
    check("sd_mis_err", r.err, 1);
    check("sd_mis_bus_req", r.saw_req, 0);

    // Timeout with ready held low
    do_access(0, 64'h8000_0010, 64'h0, 2'b11, 0, 64'h0, 1000, r);
    check("to_err", r.err, 1);
    check("to_latency", r.lat, TO + 2);
    check("to_rdata", r.rdata, 64'h0);
    check("to_bus_req", r.saw_req, 1);
    do_access(0, 64'h8000_0018, 64'h0, 2'b11, 0, 64'h0123_4567_89AB_CDEF, 0, r);
    check("after_to_rdata", r.rdata, 64'h0123_4567_89AB_CDEF);
    check("after_to_err", r.err, 0);
    check("after_to_latency", r.lat, 3);

    // Reset while waiting for the response
    @(posedge clk); #1;
    req_valid = 1; req_wen = 0; req_addr = 64'h8000_0020; req_size = 2'b11; req_unsigned = 0;
    bus_req_ready = 1; bus_resp_valid = 0; bus_resp_rdata = 64'hAAAA_5555_AAAA_5555;
    in_resp = 0;
    for (int c = 0; c < 10 && !in_resp; c++) begin
      @(negedge clk);
      in_resp = bus_resp_ready;
    end
    check("rr_reached_resp", in_resp, 1);
    @(posedge clk); #1;
    rst = 1; bus_req_ready = 0;
    #1;
    check("rr_stall", stall, 0);
    check("rr_resp_ready", bus_resp_ready, 0);
    check("rr_done", done, 0);
    @(posedge clk); #2;
    check("rr_after_edge_resp_ready", bus_resp_ready, 0);
    check("rr_after_edge_req_valid", bus_req_valid, 0);
    rst = 0; req_valid = 0; bus_resp_valid = 1;
    repeat (2) begin
      @(posedge clk); #2;
      check("late_resp_done", done, 0);
      check("late_resp_ready", bus_resp_ready, 0);
    end
    bus_resp_valid = 0;
    do_access(0, 64'h8000_0028, 64'h0, 2'b11, 0, 64'h0F0E_0D0C_0B0A_0908, 0, r);
    check("after_rst_rdata", r.rdata, 64'h0F0E_0D0C_0B0A_0908);
    check("after_rst_latency", r.lat, 3);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
